dac_sample_pacer: RTL and testbench

DAC_SAMPLE_PACER -- requirements
Module: dac_sample_pacer

---
 rtl/dac_pkg.sv | 10 +
 rtl/dac_fifo.sv | 76 +++++++
 rtl/dac_sample_pacer.sv | 97 +++++++++
 tb/tb_dac_sample_pacer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants for the DAC sample pacer: bus width, midscale code and
// default FIFO depth / rate-divider width.
package dac_pkg;

    localparam int DAC_DATA_W = 10;
    localparam logic [DAC_DATA_W-1:0] DAC_MIDSCALE = 10'd512;
    localparam int DAC_DEPTH = 8;
    localparam int DAC_DIV_W = 8;

endpackage

// File: rtl/dac_fifo.sv
// Synchronous single-clock FIFO with a show-ahead head output; pointers wrap
// modulo DEPTH and an explicit occupancy counter distinguishes full from empty.
module dac_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              do_push_s, do_pop_s;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == (AW+1)'(0));
    assign level_o   = level_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces buffered core samples onto the DAC data bus at a programmable tick rate,
// flagging ticks that find the buffer empty.
module dac_sample_pacer
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W,
    parameter int DEPTH  = DAC_DEPTH,
    parameter int DIV_W  = DAC_DIV_W
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       rate_div,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clr_underflow,
    output logic [DATA_W-1:0]      dac_d,
    output logic                   underflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam logic [DATA_W-1:0] MIDSCALE_C = (DATA_W == DAC_DATA_W) ?
        DATA_W'(DAC_MIDSCALE) : {1'b1, {(DATA_W-1){1'b0}}};

    logic [DIV_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dac_q, dac_d_s;
    logic              underflow_q, underflow_d;
    logic              tick_s, pop_s, push_s;
    logic              full_s, empty_s;
    logic [DATA_W-1:0] head_s;

    // A push landing this cycle is invisible to this cycle's tick, since
    // empty_s comes from the registered occupancy.
    assign tick_s   = enable && (count_q == rate_div);
    assign pop_s    = tick_s && !empty_s;
    assign in_ready = !full_s;
    assign push_s   = in_valid && in_ready;

    dac_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .reset     (reset),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .wr_data_i (in_data),
        .head_o    (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .level_o   (level)
    );

    // Tick counter, output code and sticky underflow next-state.
    always_comb begin
        count_d     = count_q;
        dac_d_s     = dac_q;
        underflow_d = underflow_q;
        if (!enable) begin
            count_d = DIV_W'(0);
        end else if (count_q >= rate_div) begin
            count_d = DIV_W'(0);
        end else begin
            count_d = count_q + DIV_W'(1);
        end
        if (pop_s) begin
            dac_d_s = head_s;
        end else begin
            dac_d_s = dac_q;
        end
        if (tick_s && empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Pacer state registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q     <= DIV_W'(0);
            dac_q       <= MIDSCALE_C;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            dac_q       <= dac_d_s;
            underflow_q <= underflow_d;
        end
    end

    assign dac_d     = dac_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed and randomised bench for dac_sample_pacer with a cycle model whose
// sample queue acts as the scoreboard for the DAC output stream.
module tb_dac_sample_pacer;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 8;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  rate_div = 8'd0;
    logic [DATA_W-1:0] in_data = 10'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              clr_underflow = 1'b0;
    logic [DATA_W-1:0] dac_d;
    logic              underflow;
    logic [3:0]        level;

    int checks = 0;
    int errors = 0;

    // Reference model state; m_q holds the samples expected to reach dac_d.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_dac = 10'd512;
    logic              m_uf = 1'b0;
    int                m_count = 0;

    dac_sample_pacer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .DIV_W  (DIV_W)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .enable        (enable),
        .rate_div      (rate_div),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .clr_underflow (clr_underflow),
        .dac_d         (dac_d),
        .underflow     (underflow),
        .level         (level)
    );

    always #5 CLK = ~CLK;

    // Cycle model: acceptance uses pre-edge occupancy, pop happens before push.
    always @(posedge CLK) begin
        logic m_tick, m_push, m_empty;
        if (reset) begin
            m_q.delete();
            m_count = 0;
            m_uf    = 1'b0;
            m_dac   = 10'd512;
        end else begin
            m_tick  = enable && (m_count == int'(rate_div));
            m_push  = in_valid && (m_q.size() < DEPTH);
            m_empty = (m_q.size() == 0);
            if (m_tick && !m_empty) m_dac = m_q.pop_front();
            if (m_tick && m_empty) m_uf = 1'b1;
            else if (clr_underflow) m_uf = 1'b0;
            if (m_push) m_q.push_back(in_data);
            if (!enable || m_count >= int'(rate_div)) m_count = 0;
            else m_count = m_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dac_d"}, 32'(dac_d), 32'(m_dac));
        chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_q.size() != DEPTH));
    endtask

    task automatic cyc(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk_model(tag);
        end
    endtask

    initial begin
        // Reset state
        cyc("reset", 2);
        reset = 1'b0;
        cyc("post_reset", 1);
        chk("reset.dac_d", 32'(dac_d), 32'h200);
        chk("reset.level", 32'(level), 32'd0);
        chk("reset.underflow", 32'(underflow), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream at rate_div=0
        enable = 1'b1; rate_div = 8'd0;
        in_valid = 1'b1; in_data = 10'd1;
        cyc("stream0", 1);
        chk("stream0.first_uf", 32'(underflow), 32'd1);
        in_data = 10'd2;
        cyc("stream0", 1);
        chk("stream0.d1", 32'(dac_d), 32'd1);
        in_data = 10'd3;
        cyc("stream0", 1);
        chk("stream0.d2", 32'(dac_d), 32'd2);
        in_valid = 1'b0;
        cyc("stream0", 1);
        chk("stream0.d3", 32'(dac_d), 32'd3);
        cyc("stream0", 3);
        chk("stream0.hold", 32'(dac_d), 32'd3);

        // Clear coinciding with an empty tick keeps the flag; a lone clear drops it
        clr_underflow = 1'b1;
        cyc("clr_tick", 1);
        chk("clr_tick.uf", 32'(underflow), 32'd1);
        enable = 1'b0;
        cyc("clr_idle", 1);
        chk("clr_idle.uf", 32'(underflow), 32'd0);
        clr_underflow = 1'b0;

        // Fill to full with in_valid held, then pace out at rate_div=3
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 10'(16 + i);
            cyc("fill", 1);
        end
        chk("fill.level", 32'(level), 32'd8);
        chk("fill.ready", 32'(in_ready), 32'd0);
        rate_div = 8'd3; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 10'(64 + i);
            cyc("full_pace", 1);
        end
        in_valid = 1'b0;
        cyc("drain", 10);

        // Enable dropped mid-stream
        enable = 1'b0;
        cyc("pause", 10);
        enable = 1'b1;
        cyc("resume", 40);
        chk("drain.level", 32'(level), 32'd0);

        // Rate change below the running count restarts without a tick
        in_valid = 1'b1; in_data = 10'h155;
        rate_div = 8'd7;
        cyc("rate7", 5);
        in_valid = 1'b0;
        rate_div = 8'd2;
        cyc("rate2", 8);

        // Reset with a partially full FIFO and a full-scale output code
        enable = 1'b0;
        in_valid = 1'b1; in_data = 10'h3FF;
        cyc("preload", 1);
        in_valid = 1'b0; rate_div = 8'd0;
        while (m_q.size() > 1) begin
            enable = 1'b1;
            cyc("flush", 1);
        end
        enable = 1'b1;
        cyc("flush", 1);
        enable = 1'b0;
        chk("pre_rst.dac", 32'(dac_d), 32'h3FF);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 10'(100 + i);
            cyc("load5", 1);
        end
        in_valid = 1'b0;
        chk("load5.level", 32'(level), 32'd5);
        reset = 1'b1; enable = 1'b1;
        cyc("mid_reset", 1);
        chk("mid_reset.dac", 32'(dac_d), 32'h200);
        chk("mid_reset.level", 32'(level), 32'd0);
        chk("mid_reset.uf", 32'(underflow), 32'd0);
        reset = 1'b0;
        cyc("after_reset", 2);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_data       = 10'($urandom_range(0, 1023));
            enable        = ($urandom_range(0, 9) != 0);
            clr_underflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) rate_div = 8'($urandom_range(0, 4));
            cyc("random", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
